// File: rtl/kbd_video_hotkeys.sv
// kbd_video_hotkeys: PS/2 set-2 hotkey decoder for video colour mode and CPU speed.
// Ctrl+Alt+F11 cycles colour, Ctrl+Alt+F12 cycles speed, Ctrl+Alt+F10 restores defaults.
module kbd_video_hotkeys #(
    parameter logic [1:0] MONO_RESET  = 2'd0,
    parameter logic [1:0] SPEED_RESET = 2'd0,
    parameter logic [1:0] SPEED_MAX   = 2'd2
) (
    input  logic       clk_kb,
    input  logic       rst_n,
    input  logic       scan_valid,
    input  logic [7:0] scan_code,
    output logic [1:0] monochrome_switcher,
    output logic [1:0] cpu_speed_switcher,
    output logic       mode_changed
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK,
        S_PAUSE
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] skip_q, skip_d;
    logic       lctrl_q, lctrl_d;
    logic       rctrl_q, rctrl_d;
    logic       lalt_q, lalt_d;
    logic       ralt_q, ralt_d;
    logic       f10_dn_q, f10_dn_d;
    logic       f11_dn_q, f11_dn_d;
    logic       f12_dn_q, f12_dn_d;
    logic [1:0] mono_q, mono_d;
    logic [1:0] speed_q, speed_d;
    logic       mc_q, mc_d;

    logic       key_ev;
    logic       key_ext;
    logic       key_mk;
    logic       bat_clr;
    logic       hot;

    // Modifiers are sampled from the registered flags, so byte N's
    // modifier update is already visible when byte N+1 arrives.
    assign hot = (lctrl_q | rctrl_q) & (lalt_q | ralt_q);

    // Byte parser: prefix tracking, Pause skipping, key event decode.
    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        key_ev  = 1'b0;
        key_ext = 1'b0;
        key_mk  = 1'b1;
        bat_clr = 1'b0;
        if (scan_valid) begin
            case (state_q)
                S_IDLE: begin
                    case (scan_code)
                        8'hE0: state_d = S_EXT;
                        8'hF0: state_d = S_BRK;
                        8'hE1: begin
                            state_d = S_PAUSE;
                            skip_d  = 3'd7;
                        end
                        8'hAA: bat_clr = 1'b1;
                        8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: ;
                        default: key_ev = 1'b1;
                    endcase
                end
                S_EXT: begin
                    if (scan_code == 8'hF0) begin
                        state_d = S_EXT_BRK;
                    end else begin
                        key_ev  = 1'b1;
                        key_ext = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                S_BRK: begin
                    key_ev  = 1'b1;
                    key_mk  = 1'b0;
                    state_d = S_IDLE;
                end
                S_EXT_BRK: begin
                    key_ev  = 1'b1;
                    key_ext = 1'b1;
                    key_mk  = 1'b0;
                    state_d = S_IDLE;
                end
                S_PAUSE: begin
                    skip_d = skip_q - 3'd1;
                    // Guard against a zero count so PAUSE can never stick.
                    if (skip_q <= 3'd1) begin
                        skip_d  = 3'd0;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Modifier/held flags and hotkey actions.
    always_comb begin
        lctrl_d  = lctrl_q;
        rctrl_d  = rctrl_q;
        lalt_d   = lalt_q;
        ralt_d   = ralt_q;
        f10_dn_d = f10_dn_q;
        f11_dn_d = f11_dn_q;
        f12_dn_d = f12_dn_q;
        mono_d   = mono_q;
        speed_d  = speed_q;
        if (bat_clr) begin
            lctrl_d  = 1'b0;
            rctrl_d  = 1'b0;
            lalt_d   = 1'b0;
            ralt_d   = 1'b0;
            f10_dn_d = 1'b0;
            f11_dn_d = 1'b0;
            f12_dn_d = 1'b0;
        end else if (key_ev) begin
            case (scan_code)
                8'h14: begin
                    if (key_ext) rctrl_d = key_mk;
                    else         lctrl_d = key_mk;
                end
                8'h11: begin
                    if (key_ext) ralt_d = key_mk;
                    else         lalt_d = key_mk;
                end
                8'h09: begin
                    if (!key_ext) begin
                        f10_dn_d = key_mk;
                        if (key_mk && hot && !f10_dn_q) begin
                            mono_d  = MONO_RESET;
                            speed_d = SPEED_RESET;
                        end
                    end
                end
                8'h78: begin
                    if (!key_ext) begin
                        f11_dn_d = key_mk;
                        if (key_mk && hot && !f11_dn_q)
                            mono_d = mono_q + 2'd1;
                    end
                end
                8'h07: begin
                    if (!key_ext) begin
                        f12_dn_d = key_mk;
                        if (key_mk && hot && !f12_dn_q)
                            speed_d = (speed_q >= SPEED_MAX) ? 2'd0
                                                             : speed_q + 2'd1;
                    end
                end
                default: ;
            endcase
        end
        mc_d = (mono_d != mono_q) || (speed_d != speed_q);
    end

    // State and output registers.
    always_ff @(posedge clk_kb or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            skip_q   <= 3'd0;
            lctrl_q  <= 1'b0;
            rctrl_q  <= 1'b0;
            lalt_q   <= 1'b0;
            ralt_q   <= 1'b0;
            f10_dn_q <= 1'b0;
            f11_dn_q <= 1'b0;
            f12_dn_q <= 1'b0;
            mono_q   <= MONO_RESET;
            speed_q  <= SPEED_RESET;
            mc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            skip_q   <= skip_d;
            lctrl_q  <= lctrl_d;
            rctrl_q  <= rctrl_d;
            lalt_q   <= lalt_d;
            ralt_q   <= ralt_d;
            f10_dn_q <= f10_dn_d;
            f11_dn_q <= f11_dn_d;
            f12_dn_q <= f12_dn_d;
            mono_q   <= mono_d;
            speed_q  <= speed_d;
            mc_q     <= mc_d;
        end
    end

    assign monochrome_switcher = mono_q;
    assign cpu_speed_switcher  = speed_q;
    assign mode_changed        = mc_q;

endmodule

// File: tb/tb_kbd_video_hotkeys.sv
// tb_kbd_video_hotkeys: directed and random scan-code streams checked
// against a key-table reference model of the hotkey rules.
module tb_kbd_video_hotkeys;

    localparam int MONO_R  = 0;
    localparam int SPEED_R = 0;
    localparam int SPEED_M = 2;

    logic       clk_kb = 1'b0;
    logic       rst_n = 1'b0;
    logic       scan_valid = 1'b0;
    logic [7:0] scan_code = 8'h00;
    logic [1:0] monochrome_switcher;
    logic [1:0] cpu_speed_switcher;
    logic       mode_changed;

    kbd_video_hotkeys #(
        .MONO_RESET (2'(MONO_R)),
        .SPEED_RESET(2'(SPEED_R)),
        .SPEED_MAX  (2'(SPEED_M))
    ) dut (
        .clk_kb             (clk_kb),
        .rst_n              (rst_n),
        .scan_valid         (scan_valid),
        .scan_code          (scan_code),
        .monochrome_switcher(monochrome_switcher),
        .cpu_speed_switcher (cpu_speed_switcher),
        .mode_changed       (mode_changed)
    );

    always #5 clk_kb = ~clk_kb;

    int n_chk = 0;
    int n_bad = 0;

    // Reference model: a table of held keys (plain and extended) plus
    // prefix flags and a count of Pause bytes still to swallow.
    int m_mono, m_speed, m_pause;
    bit m_e0, m_f0, m_mc;
    bit m_held[2][256];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp,
                     $time);
        end
    endtask

    task automatic m_clear_keys();
        for (int e = 0; e < 2; e++)
            for (int k = 0; k < 256; k++)
                m_held[e][k] = 1'b0;
    endtask

    task automatic m_reset();
        m_mono  = MONO_R;
        m_speed = SPEED_R;
        m_pause = 0;
        m_e0    = 1'b0;
        m_f0    = 1'b0;
        m_mc    = 1'b0;
        m_clear_keys();
    endtask

    task automatic m_key(input logic [7:0] b, input bit ext, input bit brk);
        bit ctrl, alt, fire;
        ctrl = m_held[0][8'h14] | m_held[1][8'h14];
        alt  = m_held[0][8'h11] | m_held[1][8'h11];
        if (brk) begin
            m_held[ext][b] = 1'b0;
        end else begin
            fire = !ext && ctrl && alt && !m_held[ext][b];
            m_held[ext][b] = 1'b1;
            if (fire) begin
                if (b == 8'h78) m_mono = (m_mono + 1) % 4;
                if (b == 8'h07) m_speed = (m_speed >= SPEED_M) ? 0
                                                               : m_speed + 1;
                if (b == 8'h09) begin
                    m_mono  = MONO_R;
                    m_speed = SPEED_R;
                end
            end
        end
    endtask

    task automatic m_byte(input logic [7:0] b);
        int om, os;
        om = m_mono;
        os = m_speed;
        if (m_pause > 0) begin
            m_pause--;
        end else if (m_f0) begin
            m_key(b, m_e0, 1'b1);
            m_f0 = 1'b0;
            m_e0 = 1'b0;
        end else if (m_e0) begin
            if (b == 8'hF0) m_f0 = 1'b1;
            else begin
                m_key(b, 1'b1, 1'b0);
                m_e0 = 1'b0;
            end
        end else begin
            case (b)
                8'hE0: m_e0 = 1'b1;
                8'hF0: m_f0 = 1'b1;
                8'hE1: m_pause = 7;
                8'hAA: m_clear_keys();
                8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: ;
                default: m_key(b, 1'b0, 1'b0);
            endcase
        end
        m_mc = (om != m_mono) || (os != m_speed);
    endtask

    task automatic send(input logic v, input logic [7:0] b);
        @(negedge clk_kb);
        scan_valid = v;
        scan_code  = b;
        @(posedge clk_kb);
        if (v) m_byte(b);
        else   m_mc = 1'b0;
        #1;
        chk("mono", 32'(monochrome_switcher), 32'(m_mono));
        chk("speed", 32'(cpu_speed_switcher), 32'(m_speed));
        chk("mode_changed", 32'(mode_changed), 32'(m_mc));
    endtask

    task automatic snd(input logic [7:0] b);
        send(1'b1, b);
    endtask

    logic [7:0] tbl[16];

    initial begin
        m_reset();
        repeat (3) @(posedge clk_kb);
        #1;
        chk("rst_mono", 32'(monochrome_switcher), 32'(MONO_R));
        chk("rst_speed", 32'(cpu_speed_switcher), 32'(SPEED_R));
        chk("rst_mc", 32'(mode_changed), 0);
        @(negedge clk_kb);
        rst_n = 1'b1;

        // Lone F11 without modifiers.
        snd(8'h78); snd(8'hF0); snd(8'h78);
        send(1'b0, 8'h00);

        // F11 cycling through all four modes.
        snd(8'h14); snd(8'h11);
        repeat (4) begin
            snd(8'h78); snd(8'hF0); snd(8'h78);
        end
        chk("f11_wrap", 32'(monochrome_switcher), 0);
        snd(8'hF0); snd(8'h14); snd(8'hF0); snd(8'h11);

        // Typematic suppression and speed wrap at SPEED_MAX.
        snd(8'h14); snd(8'hE0); snd(8'h11);
        snd(8'h07); snd(8'h07); snd(8'h07);
        chk("typematic", 32'(cpu_speed_switcher), 1);
        snd(8'hF0); snd(8'h07); snd(8'h07);
        snd(8'hF0); snd(8'h07); snd(8'h07);
        chk("speed_wrap", 32'(cpu_speed_switcher), 0);
        snd(8'hF0); snd(8'h07);
        snd(8'hF0); snd(8'h14);
        snd(8'hE0); snd(8'hF0); snd(8'h11);

        // Modifier release, then right Alt.
        snd(8'h14); snd(8'h11); snd(8'hF0); snd(8'h11); snd(8'h78);
        snd(8'hF0); snd(8'h78);
        snd(8'hE0); snd(8'h11); snd(8'h78);
        snd(8'hF0); snd(8'h78); snd(8'hF0); snd(8'h14);
        snd(8'hE0); snd(8'hF0); snd(8'h11);

        // Pause sequence must not touch modifiers.
        snd(8'hE1); snd(8'h14); snd(8'h77); snd(8'hE1);
        snd(8'hF0); snd(8'h14); snd(8'hF0); snd(8'h77);
        snd(8'h11); snd(8'h78);
        snd(8'h14); snd(8'hF0); snd(8'h78); snd(8'h78);
        snd(8'hF0); snd(8'h78);

        // F10 restore from mono 2 / speed 1.
        snd(8'h09); snd(8'hF0); snd(8'h09);
        snd(8'h78); snd(8'hF0); snd(8'h78);
        snd(8'h78); snd(8'hF0); snd(8'h78);
        snd(8'h07); snd(8'hF0); snd(8'h07);
        chk("pre_f10_mono", 32'(monochrome_switcher), 2);
        chk("pre_f10_speed", 32'(cpu_speed_switcher), 1);
        snd(8'h09);
        chk("f10_pulse", 32'(mode_changed), 1);
        snd(8'hF0);
        chk("f10_one_pulse", 32'(mode_changed), 0);
        snd(8'h09);

        // Async reset mid-sequence, after an E0.
        snd(8'h78); snd(8'hF0); snd(8'h78);
        snd(8'hE0);
        @(negedge clk_kb);
        scan_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_mono", 32'(monochrome_switcher), 32'(MONO_R));
        chk("async_speed", 32'(cpu_speed_switcher), 32'(SPEED_R));
        chk("async_mc", 32'(mode_changed), 0);
        m_reset();
        @(negedge clk_kb);
        rst_n = 1'b1;
        // 14 must be LCtrl: releasing LCtrl leaves no Ctrl held.
        snd(8'h14); snd(8'h11); snd(8'hF0); snd(8'h14); snd(8'h78);
        chk("post_rst_lctrl", 32'(monochrome_switcher), 32'(MONO_R));
        snd(8'hF0); snd(8'h78); snd(8'h14); snd(8'h78);

        // Random streams with gaps.
        tbl = '{8'h14, 8'h11, 8'hE0, 8'hF0, 8'hE1, 8'h78, 8'h07, 8'h09,
                8'hAA, 8'h12, 8'h59, 8'hF0, 8'h14, 8'h11, 8'h78, 8'hFA};
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] b;
            if ($urandom_range(0, 9) == 0) b = 8'($urandom);
            else b = tbl[$urandom_range(0, 15)];
            send($urandom_range(0, 9) < 8, b);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/kbd_video_hotkeys.md
# kbd_video_hotkeys

Keyboard hotkey decoder that produces the `monochrome_switcher` and `cpu_speed_switcher` controls. Those controls feed the RGB-to-monochrome output mux and the CPU clock-divider select.

- **Input:** decoded PS/2 set-2 scan-code bytes from the keyboard controller.
- **Tracking:** Ctrl/Alt modifier state, extended (E0) prefixes, break (F0) prefixes and the Pause (E1) sequence.
- **Actions:**
  - Ctrl+Alt+F11 cycles the video colour mode.
  - Ctrl+Alt+F12 cycles the CPU speed.
  - Ctrl+Alt+F10 restores both defaults.
- **Clocking:** sits in the keyboard clock domain, alongside the keyboard controller.

## Interface
Parameters:
- `MONO_RESET`, default 2'd0. Monochrome mode after reset and after F10 (0 colour, 1 green, 2 amber, 3 grey).
- `SPEED_RESET`, default 2'd0. CPU speed select after reset and after F10.
- `SPEED_MAX`, default 2'd2. Highest legal speed select; the speed wraps to 0 after this value.

Ports:
- `clk_kb`  in  1  keyboard-domain clock; one clock, all logic on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `scan_valid`  in  1  one-cycle strobe; `scan_code` is valid this cycle.
- `scan_code`  in  8  PS/2 set-2 byte.
- `monochrome_switcher`  out  2  registered colour-mode select.
- `cpu_speed_switcher`  out  2  registered CPU divider select, never greater than `SPEED_MAX`.
- `mode_changed`  out  1  one-cycle pulse, asserted on any cycle where either select changes value.

## Operation
Parser FSM states: IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0), PAUSE (skipping bytes).

From IDLE:
- E0 -> EXT.
- F0 -> BRK.
- E1 -> PAUSE; `skip_cnt` is loaded with 7.
- AA (BAT OK) -> clears all modifier and key-held flags; stays in IDLE.
- FA, FE, EE, 00, FF -> ignored; stay in IDLE.
- Any other byte -> make code, non-extended.

From the prefix states:
- EXT: F0 -> EXT_BRK; any other byte -> make code, extended -> IDLE.
- BRK: byte -> break code, non-extended -> IDLE.
- EXT_BRK: byte -> break code, extended -> IDLE.
- PAUSE: each valid byte decrements `skip_cnt`; at 1 -> IDLE. Pause bytes never touch modifiers.

Modifier flags (set on make, cleared on break):
- `lctrl`: 14 non-extended.
- `rctrl`: 14 extended.
- `lalt`: 11 non-extended.
- `ralt`: 11 extended.
- Extended 12/59 (fake shifts) are ignored.
- `ctrl = lctrl | rctrl`; `alt = lalt | ralt`.

Held flags:
- `f10_dn`, `f11_dn`, `f12_dn` are set on non-extended make of 09/78/07 and cleared on the matching break.
- An action fires only on a make while `ctrl & alt` and the held flag was 0. Typematic repeats therefore do not re-trigger.
- The held flag is set regardless of the modifier state.

Actions:
- **F11:** `monochrome_switcher` += 1, modulo 4.
- **F12:** if `cpu_speed_switcher` >= `SPEED_MAX`, it becomes 0; otherwise it increments by 1.
- **F10:** both selects are loaded with the reset parameters. `mode_changed` pulses only if a value actually differs.

Other rules:
- Any byte with `scan_valid` = 0 is ignored.
- No output other than those listed; scan codes are not consumed or filtered downstream.

## Timing
- **Reset (async assert, sync release):**
  - `monochrome_switcher` = `MONO_RESET`.
  - `cpu_speed_switcher` = `SPEED_RESET`.
  - `mode_changed` = 0.
  - FSM = IDLE, `skip_cnt` = 0.
  - All modifier and held flags = 0.
- **Reset mid-sequence** (e.g. after E0 or inside PAUSE): state is discarded and the next byte is parsed from IDLE.
- **Latency:** a byte accepted at edge N updates the selects and `mode_changed` at edge N+1. `mode_changed` is high for exactly one cycle.
- **Back-to-back input:** `scan_valid` may be asserted every cycle. Each byte's effect is visible one cycle later, with no stalls.
- **Modifier timing:** modifier changes from byte N are applied before byte N+1 is evaluated. For example, 14 then 11 then 78 on consecutive cycles fires F11.
- **Widths:** F11 wrap is 3 -> 0. Speed compare is `>=`, so a `SPEED_RESET` above `SPEED_MAX` wraps to 0 on the first F12.

## Test plan
- **Reset values:** reset with defaults -> outputs 0/0, `mode_changed` 0; release, send 78 alone -> no change.
- **F11 cycling:** 14, 11, 78, F0 78, then repeat 78 / F0 78 three more times -> mono 1, 2, 3, 0; four single-cycle `mode_changed` pulses.
- **Typematic suppression:** hold LCtrl+RAlt (14, E0 11), send 07 07 07 (repeat), then F0 07, 07 -> speed 0 -> 1, stays 1, then 2; second press from 2 -> 0 with `SPEED_MAX` = 2.
- **Modifier release:** 14, 11, F0 11, 78 -> no change. Then E0 11, 78 -> mono increments (RAlt counts).
- **Pause sequence:** E1 14 77 E1 F0 14 F0 77, then 11, 78 -> no change (ctrl not set); then 14, F0 78, 78 -> F11 fires.
- **F10 restore and async reset:** F10 restore from mono 2 / speed 1 -> 0/0 with one pulse. E0 then `rst_n` low mid-cycle -> outputs reset immediately; next byte 14 is treated as LCtrl make.
